// File: rtl/fetch_queue.sv
// Decoupling FIFO between Fetch and the Parser: stores 60-bit fetch bundles with
// their PC tags, presents the oldest one first-word-fall-through, and flushes on redirect.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 60,
  parameter int PC_W   = 16
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [PC_W-1:0]            pc_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  output logic                       enable_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [PC_W-1:0]            pc_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Every flag comes from the registered count, so no input reaches an output combinationally.
  assign full_o   = (count == CNT_W'(DEPTH));
  assign empty_o  = (count == '0);
  assign ready_o  = !full_o;
  assign enable_o = !empty_o;
  assign count_o  = count;

  assign push = enable_i && ready_o;
  assign pop  = enable_o && ready_i;

  assign data_o = empty_o ? '0 : data_mem[rd_ptr];
  assign pc_o   = empty_o ? '0 : pc_mem[rd_ptr];

  always_ff @(posedge clock_i) begin
    if (push && !flush_i) begin
      data_mem[wr_ptr] <= data_i;
      pc_mem[wr_ptr]   <= pc_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  count_bound_a: assert property (@(posedge clock_i) disable iff (!reset_i) count <= CNT_W'(DEPTH));
  no_push_full_a: assert property (@(posedge clock_i) disable iff (!reset_i) !(push && full_o));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue; a queue-based reference model
// predicts every output each cycle and a monitor compares on the falling edge.
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 60;
  localparam int PC_W   = 16;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              enable_i;
  logic [DATA_W-1:0] data_i;
  logic [PC_W-1:0]   pc_i;
  logic              ready_o;
  logic              flush_i;
  logic              enable_o;
  logic [DATA_W-1:0] data_o;
  logic [PC_W-1:0]   pc_o;
  logic              ready_i;
  logic [2:0]        count_o;
  logic              full_o;
  logic              empty_o;

  int tests_run  = 0;
  int fail_count = 0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .enable_i(enable_i),
    .data_i  (data_i),
    .pc_i    (pc_i),
    .ready_o (ready_o),
    .flush_i (flush_i),
    .enable_o(enable_o),
    .data_o  (data_o),
    .pc_o    (pc_o),
    .ready_i (ready_i),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p,
                               input logic rdy, input logic fl);
    @(posedge clock_i);
    #1;
    enable_i = en;
    data_i   = d;
    pc_i     = p;
    ready_i  = rdy;
    flush_i  = fl;
  endtask

  // Monitor: compare outputs with the model, then fold the upcoming edge's inputs into it.
  always @(negedge clock_i) begin
    if (!reset_i) begin
      checkOutput("rst_count", 64'(count_o), 64'd0);
      checkOutput("rst_valid", 64'(enable_o), 64'd0);
      checkOutput("rst_ready", 64'(ready_o), 64'd1);
      checkOutput("rst_data",  64'(data_o), 64'd0);
      checkOutput("rst_pc",    64'(pc_o), 64'd0);
      exp_q.delete();
    end else begin
      int   sz;
      logic do_pop;
      logic do_push;
      sz = exp_q.size();
      checkOutput("count", 64'(count_o), 64'(sz));
      checkOutput("empty", 64'(empty_o), 64'(sz == 0));
      checkOutput("full",  64'(full_o), 64'(sz == DEPTH));
      checkOutput("ready", 64'(ready_o), 64'(sz != DEPTH));
      checkOutput("valid", 64'(enable_o), 64'(sz != 0));
      checkOutput("data",  64'(data_o), (sz == 0) ? 64'd0 : 64'(exp_q[0].data));
      checkOutput("pc",    64'(pc_o), (sz == 0) ? 64'd0 : 64'(exp_q[0].pc));
      if (flush_i) begin
        exp_q.delete();
      end else begin
        do_pop  = ready_i && (sz > 0);
        do_push = enable_i && (sz < DEPTH);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back('{pc: pc_i, data: data_i});
      end
    end
  end

  initial begin
    logic [63:0] rnd;
    int          pen;
    int          prdy;
    reset_i  = 1'b0;
    enable_i = 1'b0;
    data_i   = '0;
    pc_i     = '0;
    ready_i  = 1'b0;
    flush_i  = 1'b0;
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b1;

    // Fill to full with A..D while the Parser stalls.
    applyStimulus(1'b1, 60'h111111111111111, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 60'h222222222222222, 16'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 60'h333333333333333, 16'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 60'h444444444444444, 16'd3, 1'b0, 1'b0);
    // E offered while full must be dropped, then drain.
    applyStimulus(1'b1, 60'hEEEEEEEEEEEEEEE, 16'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 60'hEEEEEEEEEEEEEEE, 16'd4, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Single push into empty, then build count 2 and stream push+pop for 6 cycles.
    applyStimulus(1'b1, 60'h0000000000000F1, 16'h0010, 1'b0, 1'b0);
    applyStimulus(1'b1, 60'h0000000000000F2, 16'h0011, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 60'(64'h100 + 64'(i)), 16'(16'h20 + 16'(i)), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Reach count 3, then flush together with push and pop.
    applyStimulus(1'b1, 60'h0000000000000F3, 16'h0012, 1'b0, 1'b0);
    applyStimulus(1'b1, 60'hBADBADBADBADBAD, 16'h0BAD, 1'b1, 1'b1);
    applyStimulus(1'b1, 60'h000000000000ABC, 16'h0040, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Count 2, then asynchronous reset between edges.
    applyStimulus(1'b1, 60'h0000000000000C1, 16'h0051, 1'b0, 1'b0);
    applyStimulus(1'b1, 60'h0000000000000C2, 16'h0052, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clock_i);
    #2 reset_i = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(enable_o), 64'd0);
    checkOutput("async_rst_count", 64'(count_o), 64'd0);
    @(posedge clock_i);
    #1 reset_i = 1'b1;
    applyStimulus(1'b1, 60'h0000000000000D1, 16'h0061, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Random traffic with shifting push/pop bias to visit full, empty and flush cases.
    for (int seg = 0; seg < 10; seg++) begin
      pen  = $urandom_range(20, 95);
      prdy = $urandom_range(20, 95);
      for (int c = 0; c < 40; c++) begin
        rnd = {$urandom(), $urandom()};
        applyStimulus($urandom_range(0, 99) < pen, rnd[DATA_W-1:0], 16'($urandom()),
                      $urandom_range(0, 99) < prdy, $urandom_range(0, 99) < 4);
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(posedge clock_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the Fetch unit and the Parser.
- Captures each 60-bit fetch bundle (two 30-bit instructions) together with the PC it was fetched from.
- Presents the oldest bundle to the Parser with a valid/ready handshake, so a Parser stall does not lose fetched bundles.
- The Branch unit flushes it on a PC redirect, discarding wrong-path bundles.

Parameters:
- DEPTH, 4: number of bundle entries. Must be a power of two and ≥2.
- DATA_W, 60: bundle width, two 30-bit instructions.
- PC_W, 16: fetch PC tag width.

Ports:
- clock_i  input  1  core clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  Fetch bundle valid.
- data_i  input  DATA_W  Fetch bundle.
- pc_i  input  PC_W  PC of data_i.
- ready_o  output  1  queue can accept a bundle this cycle.
- flush_i  input  1  synchronous redirect flush from the Branch unit.
- enable_o  output  1  head bundle valid to the Parser.
- data_o  output  DATA_W  head bundle.
- pc_o  output  PC_W  head bundle PC.
- ready_i  input  1  Parser accepts the head bundle this cycle.
- count_o  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.

Behaviour:
- Reset (reset_i=0, asynchronous, no clock required):
  - pointers and count cleared to 0.
  - Outputs: count_o=0, empty_o=1, full_o=0, ready_o=1, enable_o=0, data_o=0, pc_o=0.
  - Storage contents need not be cleared.
- Reset release is synchronised by the clock. The first push is accepted on the first rising edge with reset_i=1.
- Flags, all decoded from registered state only (no combinational path from ready_i or enable_i to any output):
  - ready_o = !full_o.
  - enable_o = !empty_o.
- Push = enable_i && ready_o. Bundle and PC are written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop = enable_o && ready_i. rd_ptr increments modulo DEPTH.
- data_o/pc_o are driven from the entry at rd_ptr (first-word fall-through). They are 0 whenever empty_o=1.
- Latency:
  - A bundle pushed into an empty queue at edge N appears on data_o with enable_o=1 after edge N.
  - No same-cycle bypass from data_i to data_o.
- Count updates:
  - push only: +1.
  - pop only: -1.
  - push and pop together: count unchanged; both pointers advance.
- Full: ready_o=0, so enable_i is ignored and the data is not stored. A pop in the full cycle frees a slot, but ready_o only rises after that edge (no full pass-through).
- Empty: ready_i is ignored; no pointer movement; count_o never underflows.
- Flush (flush_i=1 at a rising edge):
  - pointers and count return to 0 after that edge.
  - Any push or pop in the same cycle is discarded; flush has priority.
  - enable_o=0 from the next cycle.
  - Sequence: flush > push/pop.
- Reset asserted mid-operation: all state is lost immediately; no partial bundles survive.
- Every 60-bit bundle is transferred whole; the queue does not inspect or split it.
- Under simulation, an assertion fires if count_o > DEPTH or if a push occurs while full_o=1.

Test Plan:
- Reset, then push bundles A..D (pc 0,1,2,3) with ready_i=0 -> count_o increments 1..4; full_o=1 and ready_o=0 after the 4th; data_o=A, pc_o=0 throughout.
- From full, hold enable_i=1 with bundle E for 2 cycles while ready_i=0 -> E is not stored; count_o stays 4. Then set ready_i=1 for 4 cycles -> outputs A,B,C,D in order; empty_o=1 afterwards.
- Push into an empty queue at edge N -> enable_o=1 and data_o equals the pushed bundle after edge N, not before. With simultaneous push/pop at count 2 over 6 cycles -> count_o stays 2; pointers wrap correctly; order preserved.
- Queue at count 3, assert flush_i together with enable_i=1 and ready_i=1 -> after the edge count_o=0, enable_o=0, data_o=0. Next push of bundle 60'h0ABC at pc 16'h0040 appears alone at the head.
- Queue at count 2, drive reset_i low between clock edges -> enable_o=0 and count_o=0 immediately, without waiting for an edge. After release, the first push is accepted normally.
